// File: rtl/lock_supervisor.sv
// Combination-lock supervisor: captures a 6-digit code, checks it against the
// unlock combination, opens on a match and locks out after repeated failures.
// Partial entries are discarded after an idle timeout.
// Optional build macro LOCK_PROGRAM_EN adds a prog input and a reprogrammable
// combination register; without it the combination is the constant COMBO.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_ENTRY   | collecting digits; idle timer discards a partial entry
// ST_CHECK   | one-cycle compare of the captured code against the combination
// ST_OPEN    | unlocked; waits for relock (or prog when programming is built)
// ST_LOCKOUT | all entry ignored until the lockout timer expires
// ST_PROG    | (LOCK_PROGRAM_EN only) collecting a new 6-digit combination
module lock_supervisor #(
  parameter logic [5:0] COMBO          = 6'b110_110,
  parameter int         MAX_FAIL       = 3,
  parameter int         LOCKOUT_CYCLES = 16,
  parameter int         ENTRY_TIMEOUT  = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enter,
  input  logic       in_1,
  input  logic       in_0,
  input  logic       relock,
`ifdef LOCK_PROGRAM_EN
  input  logic       prog,
`endif
  output logic [6:0] seg_disp,
  output logic       unlocked,
  output logic       lockout,
  output logic [1:0] fail_cnt,
  output logic [2:0] digit_cnt
);

  localparam logic [6:0] SEG_LOCKED  = 7'b1000_111;
  localparam logic [6:0] SEG_OPEN    = 7'b1000_001;
  localparam logic [6:0] SEG_LOCKOUT = 7'b0111_111;

  localparam logic [1:0] FAIL_MAX  = 2'(MAX_FAIL);
  // Lockout timer counts LOCKOUT_CYCLES-1 down to 0 so the state lasts
  // exactly LOCKOUT_CYCLES clocks.
  localparam logic [7:0] LOCK_LOAD = 8'(LOCKOUT_CYCLES - 1);
  localparam logic [7:0] IDLE_LOAD = 8'(ENTRY_TIMEOUT);

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_CHECK   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_LOCKOUT = 3'd3
`ifdef LOCK_PROGRAM_EN
    , ST_PROG  = 3'd4
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] capture_q, capture_d;
  logic [2:0] digit_d;
  logic       bad_q, bad_d;
  logic [1:0] fail_d;
  logic [7:0] lock_tmr_q, lock_tmr_d;
  logic [7:0] idle_tmr_q, idle_tmr_d;
  logic [6:0] seg_d;
  logic       unlocked_d;
  logic       lockout_d;
  logic [5:0] combo_q;
  logic       digit_bad;

  assign digit_bad = (in_1 == in_0);

`ifdef LOCK_PROGRAM_EN
  logic [5:0] combo_d;
`else
  assign combo_q = COMBO;
`endif

  // State and datapath registers; reset dominates every other input.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_ENTRY;
      capture_q  <= '0;
      digit_cnt  <= '0;
      bad_q      <= 1'b0;
      fail_cnt   <= '0;
      lock_tmr_q <= '0;
      idle_tmr_q <= '0;
      seg_disp   <= SEG_LOCKED;
      unlocked   <= 1'b0;
      lockout    <= 1'b0;
`ifdef LOCK_PROGRAM_EN
      combo_q    <= COMBO;
`endif
    end else begin
      state_q    <= state_d;
      capture_q  <= capture_d;
      digit_cnt  <= digit_d;
      bad_q      <= bad_d;
      fail_cnt   <= fail_d;
      lock_tmr_q <= lock_tmr_d;
      idle_tmr_q <= idle_tmr_d;
      seg_disp   <= seg_d;
      unlocked   <= unlocked_d;
      lockout    <= lockout_d;
`ifdef LOCK_PROGRAM_EN
      combo_q    <= combo_d;
`endif
    end
  end

  // Next-state and next-datapath logic; outputs are decoded from the next
  // state so the display changes on the same edge as the state register.
  always_comb begin
    state_d    = state_q;
    capture_d  = capture_q;
    digit_d    = digit_cnt;
    bad_d      = bad_q;
    fail_d     = fail_cnt;
    lock_tmr_d = lock_tmr_q;
    idle_tmr_d = idle_tmr_q;
`ifdef LOCK_PROGRAM_EN
    combo_d    = combo_q;
`endif

    case (state_q)
      ST_ENTRY: begin
        if (enter) begin
          // Invalid digits are still shifted in so the attempt costs a try.
          capture_d  = {capture_q[4:0], in_1};
          digit_d    = digit_cnt + 3'd1;
          bad_d      = bad_q | digit_bad;
          idle_tmr_d = IDLE_LOAD;
          if (digit_cnt == 3'd5) state_d = ST_CHECK;
        end else if (digit_cnt != 3'd0) begin
          if (idle_tmr_q <= 8'd1) begin
            capture_d  = '0;
            digit_d    = '0;
            bad_d      = 1'b0;
            idle_tmr_d = '0;
          end else begin
            idle_tmr_d = idle_tmr_q - 8'd1;
          end
        end
      end

      ST_CHECK: begin
        idle_tmr_d = '0;
        if ((capture_q == combo_q) && !bad_q) begin
          state_d = ST_OPEN;
          fail_d  = '0;
        end else begin
          capture_d = '0;
          digit_d   = '0;
          bad_d     = 1'b0;
          if (fail_cnt < FAIL_MAX) fail_d = fail_cnt + 2'd1;
          if (fail_d == FAIL_MAX) begin
            state_d    = ST_LOCKOUT;
            lock_tmr_d = LOCK_LOAD;
          end else begin
            state_d = ST_ENTRY;
          end
        end
      end

      ST_OPEN: begin
        if (relock) begin
          state_d   = ST_ENTRY;
          capture_d = '0;
          digit_d   = '0;
          bad_d     = 1'b0;
        end
`ifdef LOCK_PROGRAM_EN
        else if (prog) begin
          state_d   = ST_PROG;
          capture_d = '0;
          digit_d   = '0;
          bad_d     = 1'b0;
        end
`endif
      end

      ST_LOCKOUT: begin
        if (lock_tmr_q == 8'd0) begin
          state_d = ST_ENTRY;
          fail_d  = '0;
        end else begin
          lock_tmr_d = lock_tmr_q - 8'd1;
        end
      end

`ifdef LOCK_PROGRAM_EN
      ST_PROG: begin
        if (enter) begin
          if (digit_bad) begin
            // Abort leaves the stored combination untouched.
            state_d   = ST_OPEN;
            capture_d = '0;
            digit_d   = '0;
          end else if (digit_cnt == 3'd5) begin
            combo_d   = {capture_q[4:0], in_1};
            state_d   = ST_OPEN;
            capture_d = '0;
            digit_d   = '0;
          end else begin
            capture_d = {capture_q[4:0], in_1};
            digit_d   = digit_cnt + 3'd1;
          end
        end
      end
`endif

      default: begin
        state_d    = ST_ENTRY;
        capture_d  = '0;
        digit_d    = '0;
        bad_d      = 1'b0;
        fail_d     = '0;
        lock_tmr_d = '0;
        idle_tmr_d = '0;
      end
    endcase

    seg_d      = SEG_LOCKED;
    unlocked_d = 1'b0;
    lockout_d  = 1'b0;
    case (state_d)
      ST_OPEN: begin
        seg_d      = SEG_OPEN;
        unlocked_d = 1'b1;
      end
      ST_LOCKOUT: begin
        seg_d     = SEG_LOCKOUT;
        lockout_d = 1'b1;
      end
`ifdef LOCK_PROGRAM_EN
      ST_PROG: seg_d = SEG_OPEN;
`endif
      default: seg_d = SEG_LOCKED;
    endcase
  end

endmodule

// File: tb/tb_lock_supervisor.sv
// Self-checking bench for lock_supervisor: directed scenarios plus a
// randomized run compared cycle by cycle against a queue-based lock model.
module tb_lock_supervisor;

  localparam logic [5:0] COMBO          = 6'b110_110;
  localparam int         MAX_FAIL       = 3;
  localparam int         LOCKOUT_CYCLES = 16;
  localparam int         ENTRY_TIMEOUT  = 32;

  localparam logic [6:0] SEG_LOCKED  = 7'b1000_111;
  localparam logic [6:0] SEG_OPEN    = 7'b1000_001;
  localparam logic [6:0] SEG_LOCKOUT = 7'b0111_111;

`ifdef LOCK_PROGRAM_EN
  localparam bit PROG_EN = 1'b1;
`else
  localparam bit PROG_EN = 1'b0;
`endif

  localparam int MD_ENTRY   = 0;
  localparam int MD_CHECK   = 1;
  localparam int MD_OPEN    = 2;
  localparam int MD_LOCKOUT = 3;
  localparam int MD_PROG    = 4;

  logic       clock;
  logic       reset;
  logic       enter;
  logic       in_1;
  logic       in_0;
  logic       relock;
`ifdef LOCK_PROGRAM_EN
  logic       prog;
`endif
  logic [6:0] seg_disp;
  logic       unlocked;
  logic       lockout;
  logic [1:0] fail_cnt;
  logic [2:0] digit_cnt;

  int checks;
  int failures;

  // reference model state
  int         m_mode;
  bit         m_q[$];
  bit         m_bad;
  int         m_fail;
  int         m_idle;
  int         m_lock_left;
  logic [5:0] m_combo;

  lock_supervisor dut (
    .clock    (clock),
    .reset    (reset),
    .enter    (enter),
    .in_1     (in_1),
    .in_0     (in_0),
    .relock   (relock),
`ifdef LOCK_PROGRAM_EN
    .prog     (prog),
`endif
    .seg_disp (seg_disp),
    .unlocked (unlocked),
    .lockout  (lockout),
    .fail_cnt (fail_cnt),
    .digit_cnt(digit_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [5:0] pack_q();
    logic [5:0] v;
    v = '0;
    foreach (m_q[i]) v = {v[4:0], m_q[i]};
    return v;
  endfunction

  task automatic model_reset();
    m_mode      = MD_ENTRY;
    m_q.delete();
    m_bad       = 1'b0;
    m_fail      = 0;
    m_idle      = 0;
    m_lock_left = 0;
    m_combo     = COMBO;
  endtask

  task automatic model_step(input bit en, input bit i1, input bit i0, input bit rl, input bit pg);
    case (m_mode)
      MD_ENTRY: begin
        if (en) begin
          m_q.push_back(i1);
          if (i1 == i0) m_bad = 1'b1;
          m_idle = 0;
          if (m_q.size() == 6) m_mode = MD_CHECK;
        end else if (m_q.size() > 0) begin
          m_idle++;
          if (m_idle == ENTRY_TIMEOUT) begin
            m_q.delete();
            m_bad  = 1'b0;
            m_idle = 0;
          end
        end
      end
      MD_CHECK: begin
        if (pack_q() == m_combo && !m_bad) begin
          m_mode = MD_OPEN;
          m_fail = 0;
        end else begin
          m_q.delete();
          m_bad = 1'b0;
          if (m_fail < MAX_FAIL) m_fail++;
          if (m_fail == MAX_FAIL) begin
            m_mode      = MD_LOCKOUT;
            m_lock_left = LOCKOUT_CYCLES;
          end else begin
            m_mode = MD_ENTRY;
          end
        end
      end
      MD_OPEN: begin
        if (rl) begin
          m_mode = MD_ENTRY;
          m_q.delete();
          m_bad = 1'b0;
        end else if (PROG_EN && pg) begin
          m_mode = MD_PROG;
          m_q.delete();
          m_bad = 1'b0;
        end
      end
      MD_LOCKOUT: begin
        m_lock_left--;
        if (m_lock_left == 0) begin
          m_mode = MD_ENTRY;
          m_fail = 0;
        end
      end
      default: begin
        if (en) begin
          if (i1 == i0) begin
            m_mode = MD_OPEN;
            m_q.delete();
          end else begin
            m_q.push_back(i1);
            if (m_q.size() == 6) begin
              m_combo = pack_q();
              m_q.delete();
              m_mode = MD_OPEN;
            end
          end
        end
      end
    endcase
  endtask

  // One clock: drive on the falling edge, model the rising edge, settle.
  task automatic step(input bit rst, input bit en, input bit i1, input bit i0,
                      input bit rl, input bit pg);
    @(negedge clock);
    reset  = rst;
    enter  = en;
    in_1   = i1;
    in_0   = i0;
    relock = rl;
`ifdef LOCK_PROGRAM_EN
    prog   = pg;
`endif
    @(posedge clock);
    if (!rst) model_reset();
    else model_step(en, i1, i0, rl, pg);
    #1;
  endtask

  task automatic idle_step();
    step(1, 0, 0, 0, 0, 0);
  endtask

  task automatic enter_code(input logic [5:0] code);
    logic [5:0] c;
    c = code;
    for (int i = 5; i >= 0; i--) step(1, 1, c[i], ~c[i], 0, 0);
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 1, 0);
    checks++; if (seg_disp !== SEG_LOCKED) begin failures++; $display("FAIL reset_seg got %b exp %b", seg_disp, SEG_LOCKED); end
    checks++; if (unlocked !== 1'b0) begin failures++; $display("FAIL reset_unlocked got %b exp 0", unlocked); end
    checks++; if (lockout !== 1'b0) begin failures++; $display("FAIL reset_lockout got %b exp 0", lockout); end
    checks++; if (fail_cnt !== 2'd0) begin failures++; $display("FAIL reset_fail got %0d exp 0", fail_cnt); end
    checks++; if (digit_cnt !== 3'd0) begin failures++; $display("FAIL reset_digit got %0d exp 0", digit_cnt); end
  endtask

  task automatic test_unlock();
    logic [5:0] c;
    c = COMBO;
    step(0, 0, 0, 0, 0, 0);
    for (int i = 5; i >= 0; i--) begin
      step(1, 1, c[i], ~c[i], 0, 0);
      checks++; if (digit_cnt !== 3'(6 - i)) begin failures++; $display("FAIL unlock_digit got %0d exp %0d", digit_cnt, 6 - i); end
    end
    checks++; if (unlocked !== 1'b0) begin failures++; $display("FAIL unlock_early got %b exp 0", unlocked); end
    step(1, 1, 0, 0, 0, 0);
    checks++; if (unlocked !== 1'b1) begin failures++; $display("FAIL unlock_open got %b exp 1", unlocked); end
    checks++; if (seg_disp !== SEG_OPEN) begin failures++; $display("FAIL unlock_seg got %b exp %b", seg_disp, SEG_OPEN); end
    idle_step();
    checks++; if (unlocked !== 1'b1) begin failures++; $display("FAIL unlock_hold got %b exp 1", unlocked); end
    step(1, 0, 0, 0, 1, 0);
    checks++; if (unlocked !== 1'b0 || seg_disp !== SEG_LOCKED) begin failures++; $display("FAIL relock got unlocked=%b seg=%b exp 0/%b", unlocked, seg_disp, SEG_LOCKED); end
    checks++; if (digit_cnt !== 3'd0) begin failures++; $display("FAIL relock_digit got %0d exp 0", digit_cnt); end
  endtask

  task automatic test_lockout();
    int n;
    step(0, 0, 0, 0, 0, 0);
    for (int a = 1; a <= 3; a++) begin
      enter_code(6'b000_000);
      idle_step();
      if (a < 3) begin
        checks++; if (fail_cnt !== 2'(a) || lockout !== 1'b0) begin failures++; $display("FAIL lock_fail%0d got fail=%0d lockout=%b exp %0d/0", a, fail_cnt, lockout, a); end
      end
    end
    n = 0;
    while (lockout === 1'b1 && n < 40) begin
      n++;
      checks++; if (seg_disp !== SEG_LOCKOUT || digit_cnt !== 3'd0) begin failures++; $display("FAIL lock_seg got seg=%b digit=%0d exp %b/0", seg_disp, digit_cnt, SEG_LOCKOUT); end
      step(1, 1, 1, 0, 0, 0);
    end
    checks++; if (n != LOCKOUT_CYCLES) begin failures++; $display("FAIL lock_len got %0d exp %0d", n, LOCKOUT_CYCLES); end
    checks++; if (fail_cnt !== 2'd0 || seg_disp !== SEG_LOCKED) begin failures++; $display("FAIL lock_exit got fail=%0d seg=%b exp 0/%b", fail_cnt, seg_disp, SEG_LOCKED); end
  endtask

  task automatic test_timeout();
    step(0, 0, 0, 0, 0, 0);
    enter_code(6'b000_001);
    idle_step();
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < ENTRY_TIMEOUT - 1; i++) idle_step();
    checks++; if (digit_cnt !== 3'd3) begin failures++; $display("FAIL tmo_before got %0d exp 3", digit_cnt); end
    idle_step();
    checks++; if (digit_cnt !== 3'd0 || fail_cnt !== 2'd1) begin failures++; $display("FAIL tmo_discard got digit=%0d fail=%0d exp 0/1", digit_cnt, fail_cnt); end
    enter_code(COMBO);
    idle_step();
    checks++; if (unlocked !== 1'b1 || fail_cnt !== 2'd0) begin failures++; $display("FAIL tmo_open got unlocked=%b fail=%0d exp 1/0", unlocked, fail_cnt); end
  endtask

  task automatic test_bad_digit();
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    step(1, 1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    idle_step();
    checks++; if (unlocked !== 1'b0 || fail_cnt !== 2'd1) begin failures++; $display("FAIL bad_digit got unlocked=%b fail=%0d exp 0/1", unlocked, fail_cnt); end
  endtask

  task automatic test_reset_mid();
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    checks++; if (digit_cnt !== 3'd0 || seg_disp !== SEG_LOCKED) begin failures++; $display("FAIL rst_entry got digit=%0d seg=%b exp 0/%b", digit_cnt, seg_disp, SEG_LOCKED); end
    for (int a = 0; a < 3; a++) begin
      enter_code(6'b010_101);
      idle_step();
    end
    for (int i = 0; i < 4; i++) idle_step();
    checks++; if (lockout !== 1'b1) begin failures++; $display("FAIL rst_pre got lockout=%b exp 1", lockout); end
    step(0, 1, 1, 0, 0, 0);
    checks++; if (lockout !== 1'b0 || fail_cnt !== 2'd0 || seg_disp !== SEG_LOCKED) begin failures++; $display("FAIL rst_lockout got lockout=%b fail=%0d seg=%b exp 0/0/%b", lockout, fail_cnt, seg_disp, SEG_LOCKED); end
  endtask

`ifdef LOCK_PROGRAM_EN
  task automatic test_program();
    step(0, 0, 0, 0, 0, 0);
    enter_code(COMBO);
    idle_step();
    step(1, 0, 0, 0, 0, 1);
    enter_code(6'b001_101);
    checks++; if (unlocked !== 1'b1) begin failures++; $display("FAIL prog_back got unlocked=%b exp 1", unlocked); end
    step(1, 0, 0, 0, 1, 0);
    enter_code(COMBO);
    idle_step();
    checks++; if (unlocked !== 1'b0 || fail_cnt !== 2'd1) begin failures++; $display("FAIL prog_old got unlocked=%b fail=%0d exp 0/1", unlocked, fail_cnt); end
    enter_code(6'b001_101);
    idle_step();
    checks++; if (unlocked !== 1'b1) begin failures++; $display("FAIL prog_new got unlocked=%b exp 1", unlocked); end
  endtask
`endif

  task automatic test_random();
    int         burst;
    bit         en, i1, i0, rl, pg, rst;
    logic [6:0] e_seg;
    step(0, 0, 0, 0, 0, 0);
    burst = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst = ($urandom_range(0, 499) != 0);
      if (burst > 0) begin
        burst--;
        en = 1'b0;
      end else begin
        if ($urandom_range(0, 199) == 0) burst = $urandom_range(25, 40);
        en = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 9) == 0) begin
        i1 = 1'($urandom_range(0, 1));
        i0 = i1;
      end else begin
        if (m_q.size() < 6 && $urandom_range(0, 9) < 8) i1 = m_combo[5 - m_q.size()];
        else i1 = 1'($urandom_range(0, 1));
        i0 = ~i1;
      end
      rl = ($urandom_range(0, 7) == 0);
      pg = ($urandom_range(0, 5) == 0);
      step(rst, en, i1, i0, rl, pg);
      e_seg = (m_mode == MD_OPEN || m_mode == MD_PROG) ? SEG_OPEN :
              (m_mode == MD_LOCKOUT) ? SEG_LOCKOUT : SEG_LOCKED;
      checks++; if (seg_disp !== e_seg) begin failures++; $display("FAIL rnd_seg cyc %0d got %b exp %b", cyc, seg_disp, e_seg); end
      checks++; if (unlocked !== (m_mode == MD_OPEN)) begin failures++; $display("FAIL rnd_unlocked cyc %0d got %b exp %b", cyc, unlocked, m_mode == MD_OPEN); end
      checks++; if (lockout !== (m_mode == MD_LOCKOUT)) begin failures++; $display("FAIL rnd_lockout cyc %0d got %b exp %b", cyc, lockout, m_mode == MD_LOCKOUT); end
      checks++; if (fail_cnt !== 2'(m_fail)) begin failures++; $display("FAIL rnd_fail cyc %0d got %0d exp %0d", cyc, fail_cnt, m_fail); end
      checks++; if (digit_cnt !== 3'(m_q.size())) begin failures++; $display("FAIL rnd_digit cyc %0d got %0d exp %0d", cyc, digit_cnt, m_q.size()); end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    enter    = 1'b0;
    in_1     = 1'b0;
    in_0     = 1'b0;
    relock   = 1'b0;
`ifdef LOCK_PROGRAM_EN
    prog     = 1'b0;
`endif
    model_reset();
    test_reset();
    test_unlock();
    test_lockout();
    test_timeout();
    test_bad_digit();
    test_reset_mid();
`ifdef LOCK_PROGRAM_EN
    test_program();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lock_supervisor.md
LOCK_SUPERVISOR -- requirements
Module: lock_supervisor

Interface
REQ-001 SHALL have parameter COMBO, default 6'b110_110, the unlock code; MSB is entered first.
REQ-002 SHALL have parameter MAX_FAIL, default 3, the consecutive failed attempts that trigger lockout (range 1..3).
REQ-003 SHALL have parameter LOCKOUT_CYCLES, default 16, the lockout duration in clocks (range 1..255).
REQ-004 SHALL have parameter ENTRY_TIMEOUT, default 32, the idle clocks after which a partial entry is discarded (range 1..255).
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port enter, input, 1 bit: digit strobe; each clock sampled high submits one digit.
REQ-008 SHALL have port in_1, input, 1 bit: digit one-hot bit for value 1.
REQ-009 SHALL have port in_0, input, 1 bit: digit one-hot bit for value 0.
REQ-010 SHALL have port relock, input, 1 bit: request to leave OPEN.
REQ-011 SHALL have port seg_disp, output, 7 bits: registered display code.
REQ-012 SHALL have port unlocked, output, 1 bit: high only in OPEN.
REQ-013 SHALL have port lockout, output, 1 bit: high only in LOCKOUT.
REQ-014 SHALL have port fail_cnt, output, 2 bits: consecutive failed attempts.
REQ-015 SHALL have port digit_cnt, output, 3 bits: digits captured in the current attempt (0..6).

Function
REQ-016 SHALL implement states ENTRY, CHECK, OPEN, LOCKOUT; any illegal encoding SHALL go to ENTRY next clock with reset output values.
REQ-017 In ENTRY, enter=1 SHALL shift the digit into a 6-bit capture register and increment digit_cnt.
- valid digit: in_1^in_0=1, value in_1
- invalid digit (in_1==in_0): still consumed, attempt marked bad
REQ-018 The clock after the 6th digit is captured, state SHALL be CHECK; enter is ignored while in CHECK.
REQ-019 CHECK SHALL take exactly one cycle; match = capture==combo AND no bad digit.
REQ-020 On match, state SHALL go to OPEN, fail_cnt SHALL clear, and seg_disp SHALL be 7'b1000_001.
REQ-021 On mismatch, fail_cnt SHALL increment and capture/digit_cnt SHALL clear.
- new fail_cnt==MAX_FAIL: go to LOCKOUT, load timer with LOCKOUT_CYCLES
- otherwise: return to ENTRY
REQ-022 LOCKOUT SHALL ignore enter and decrement the timer each clock; at timer 0 it SHALL go to ENTRY with fail_cnt cleared (lockout lasts exactly LOCKOUT_CYCLES clocks).
REQ-023 OPEN SHALL hold until relock=1, then go to ENTRY next clock with capture cleared; fail_cnt is unchanged.
REQ-024 In ENTRY with digit_cnt>0, ENTRY_TIMEOUT consecutive clocks without enter SHALL discard the partial entry (digit_cnt 0) without incrementing fail_cnt; enter resets the idle counter.
REQ-025 seg_disp SHALL be 7'b1000_111 in ENTRY/CHECK, 7'b1000_001 in OPEN, 7'b0111_111 in LOCKOUT, and SHALL update in the same clock as the state register.
REQ-026 fail_cnt SHALL saturate at MAX_FAIL; no counter wraps.

Reset
REQ-027 reset=0 at a clock edge SHALL force ENTRY, capture/digit_cnt/fail_cnt/timers=0, seg_disp=7'b1000_111, unlocked=0, lockout=0, taking priority over all inputs in any state, including mid-entry and mid-lockout.
REQ-028 No initial blocks; outputs are undefined until the first reset edge.

Configuration
REQ-029 With macro LOCK_PROGRAM_EN defined, the block SHALL add input port prog (1 bit) and a 6-bit combo register reset to COMBO.
- prog=1 in OPEN enters state PROG
- the next 6 entries are captured (any entry with in_1==in_0 aborts PROG with no change)
- then combo is written and state returns to OPEN
REQ-030 Without LOCK_PROGRAM_EN, prog and PROG SHALL be absent, combo SHALL be the constant COMBO, and behaviour SHALL be otherwise identical.

Verification
REQ-031 Reset, then enter 1,1,0,1,1,0 on 6 consecutive clocks -> CHECK on the next clock, OPEN one clock later, unlocked=1, seg_disp=7'b1000_001.
REQ-032 Three wrong 6-digit attempts (defaults) -> fail_cnt 1,2, then lockout=1 for exactly 16 clocks with enter held high -> ENTRY, fail_cnt=0.
REQ-033 Enter 3 digits then idle 32 clocks -> digit_cnt=0, fail_cnt unchanged; a correct full entry then opens.
REQ-034 Entry with in_1=in_0=1 as the 4th digit, others correct -> mismatch, fail_cnt=1.
REQ-035 reset=0 mid-lockout and at digit_cnt=5 -> next clock ENTRY, all counters 0, seg_disp=7'b1000_111.
REQ-036 LOCK_PROGRAM_EN build: open, prog=1, enter 0,0,1,1,0,1, relock -> old code fails, 001101 opens.
